// File: rtl/data_memory_ext_pkg.sv
// rtl/data_memory_ext_pkg.sv - shared widths, access-size codes and FSM state type
package data_memory_ext_pkg;

    localparam int DATA_LEN     = 32;
    localparam int ADDR_LEN     = 32;
    localparam int MEM_SIZE_LEN = 2;

    localparam logic [MEM_SIZE_LEN-1:0] MEM_B = 2'b00;
    localparam logic [MEM_SIZE_LEN-1:0] MEM_H = 2'b01;
    localparam logic [MEM_SIZE_LEN-1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store shifting, load extraction/extension
module dmem_lane_align
    import data_memory_ext_pkg::*;
(
    input  logic [MEM_SIZE_LEN-1:0] size,
    input  logic                    uns,
    input  logic [1:0]              offset,
    input  logic [DATA_LEN-1:0]     w_data,
    input  logic [DATA_LEN-1:0]     rd_word,
    output logic [3:0]              byte_en,
    output logic [DATA_LEN-1:0]     w_word,
    output logic [DATA_LEN-1:0]     r_ext,
    output logic                    misalign
);

    logic [4:0]          shamt;
    logic [DATA_LEN-1:0] rd_shift;

    assign shamt    = {offset, 3'b000};
    assign rd_shift = rd_word >> shamt;

    always_comb begin
        byte_en  = '0;
        w_word   = '0;
        r_ext    = '0;
        misalign = 1'b0;
        case (size)
            MEM_B: begin
                byte_en = 4'b0001 << offset;
                w_word  = {{(DATA_LEN-8){1'b0}}, w_data[7:0]} << shamt;
                r_ext   = uns ? {{(DATA_LEN-8){1'b0}}, rd_shift[7:0]}
                              : {{(DATA_LEN-8){rd_shift[7]}}, rd_shift[7:0]};
            end
            MEM_H: begin
                misalign = offset[0];
                byte_en  = 4'b0011 << offset;
                w_word   = {{(DATA_LEN-16){1'b0}}, w_data[15:0]} << shamt;
                r_ext    = uns ? {{(DATA_LEN-16){1'b0}}, rd_shift[15:0]}
                               : {{(DATA_LEN-16){rd_shift[15]}}, rd_shift[15:0]};
            end
            MEM_W: begin
                misalign = (offset != 2'b00);
                byte_en  = 4'b1111;
                w_word   = w_data;
                r_ext    = rd_shift;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_ext.sv
// rtl/data_memory_ext.sv - latency-configurable byte-addressed data memory with req/ready/valid handshake
module data_memory_ext
    import data_memory_ext_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    we,
    input  logic [MEM_SIZE_LEN-1:0] size,
    input  logic                    uns,
    input  logic [ADDR_LEN-1:0]     addr,
    input  logic [DATA_LEN-1:0]     w_data,
    output logic                    ready,
    output logic                    rvalid,
    output logic [DATA_LEN-1:0]     r_data,
    output logic                    err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    lat_we;
    logic                    lat_uns;
    logic [MEM_SIZE_LEN-1:0] lat_size;
    logic [ADDR_LEN-1:0]     lat_addr;
    logic [DATA_LEN-1:0]     lat_wdata;

    logic [DATA_LEN-1:0] mem [DEPTH];

    logic                    accept;
    logic                    in_wait;
    logic                    go_resp;
    logic                    acc_we;
    logic                    acc_uns;
    logic [MEM_SIZE_LEN-1:0] acc_size;
    logic [ADDR_LEN-1:0]     acc_addr;
    logic [DATA_LEN-1:0]     acc_wdata;
    logic [IDX_W-1:0]        idx;
    logic                    out_of_range;
    logic                    acc_err;
    logic [3:0]              byte_en;
    logic [DATA_LEN-1:0]     w_word;
    logic [DATA_LEN-1:0]     r_ext;
    logic                    misalign;

    assign accept  = req && ready;
    assign in_wait = (state == ST_WAIT);

    // The commit edge uses the live request when LATENCY==1 (accept edge == commit edge),
    // otherwise the copy latched at accept.
    assign go_resp   = in_wait ? (cnt == CNT_W'(1)) : (accept && (LATENCY == 1));
    assign acc_we    = in_wait ? lat_we    : we;
    assign acc_uns   = in_wait ? lat_uns   : uns;
    assign acc_size  = in_wait ? lat_size  : size;
    assign acc_addr  = in_wait ? lat_addr  : addr;
    assign acc_wdata = in_wait ? lat_wdata : w_data;

    assign idx          = acc_addr[IDX_W+1:2];
    assign out_of_range = {2'b00, acc_addr[ADDR_LEN-1:2]} >= ADDR_LEN'(DEPTH);
    assign acc_err      = misalign || out_of_range;

    dmem_lane_align u_align (
        .size     (acc_size),
        .uns      (acc_uns),
        .offset   (acc_addr[1:0]),
        .w_data   (acc_wdata),
        .rd_word  (mem[idx]),
        .byte_en  (byte_en),
        .w_word   (w_word),
        .r_ext    (r_ext),
        .misalign (misalign)
    );

    // Array has no reset; rst_n gating keeps a request held during reset from writing.
    always_ff @(posedge clk) begin
        if (rst_n && go_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= w_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            rvalid    <= 1'b0;
            r_data    <= '0;
            err       <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            if (go_resp) begin
                r_data <= (!acc_we && !acc_err) ? r_ext : '0;
                err    <= acc_err;
            end
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        lat_we    <= we;
                        lat_uns   <= uns;
                        lat_size  <= size;
                        lat_addr  <= addr;
                        lat_wdata <= w_data;
                        if (LATENCY == 1) begin
                            state  <= ST_RESP;
                            ready  <= 1'b1;
                            rvalid <= 1'b1;
                        end else begin
                            state  <= ST_WAIT;
                            cnt    <= CNT_W'(LATENCY - 1);
                            ready  <= 1'b0;
                            rvalid <= 1'b0;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        ready  <= 1'b1;
                        rvalid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_RESP;
                        ready  <= 1'b1;
                        rvalid <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ready  <= 1'b1;
                    rvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ext.sv
// tb/tb_data_memory_ext.sv - scoreboard bench for data_memory_ext at LATENCY 1 and 3
module tb_data_memory_ext;
    import data_memory_ext_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [31:0] cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req1 = 1'b0, req3 = 1'b0;
    logic        we = 1'b0, uns = 1'b0;
    logic [1:0]  size = MEM_W;
    logic [31:0] addr = '0, w_data = '0;
    logic        ready1, rvalid1, err1, ready3, rvalid3, err3;
    logic [31:0] r_data1, r_data3;
    logic [31:0] cyc = '0;
    logic [31:0] last_acc = '0;
    int          checks = 0, errors = 0;
    rsp_t        exp1_q[$], act1_q[$], exp3_q[$], act3_q[$];

    data_memory_ext #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .size(size), .uns(uns),
        .addr(addr), .w_data(w_data), .ready(ready1), .rvalid(rvalid1),
        .r_data(r_data1), .err(err1));

    data_memory_ext #(.DEPTH(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size), .uns(uns),
        .addr(addr), .w_data(w_data), .ready(ready3), .rvalid(rvalid3),
        .r_data(r_data3), .err(err3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rvalid1) act1_q.push_back({err1, r_data1, cyc});
        if (rst_n && rvalid3) act3_q.push_back({err3, r_data3, cyc});
    end

    // Expected response cycle = accept-edge cycle + LATENCY - 1.
    task automatic send(input bit sel3, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit expect_rsp, input logic exp_err, input logic [31:0] exp_data);
        bit acc = 1'b0;
        we = w; size = sz; uns = u; addr = a; w_data = d;
        if (sel3) req3 = 1'b1; else req1 = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = sel3 ? ready3 : ready1;
            @(posedge clk); #1;
        end
        req1 = 1'b0; req3 = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: addr=%h never accepted, required accept within 50 cycles", a);
        end else begin
            last_acc = cyc;
            if (expect_rsp) begin
                if (sel3) exp3_q.push_back({exp_err, exp_data, cyc + 32'd2});
                else      exp1_q.push_back({exp_err, exp_data, cyc});
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready1, rvalid1, err1, r_data1} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut1: ready=%0b rvalid=%0b err=%0b r_data=%h, required 1 0 0 0",
                     ready1, rvalid1, err1, r_data1);
        end
        checks++;
        if ({ready3, rvalid3, err3, r_data3} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut3: ready=%0b rvalid=%0b err=%0b r_data=%h, required 1 0 0 0",
                     ready3, rvalid3, err3, r_data3);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_word_lane();
        rsp_t e, a;
        logic [31:0] t0;
        send(0, 1, MEM_W, 0, 32'h8, 32'hDEADBEEF, 1, 0, 32'h0);
        t0 = last_acc;
        send(0, 0, MEM_W, 0, 32'h8, 32'h0, 1, 0, 32'hDEADBEEF);
        checks++;
        if (last_acc - t0 !== 32'd1) begin
            errors++;
            $display("FAIL word_lane_throughput: gap=%0d cycles, required 1", last_acc - t0);
        end
        send(0, 1, MEM_B, 0, 32'hA, 32'h12, 1, 0, 32'h0);
        send(0, 0, MEM_W, 0, 32'h8, 32'h0, 1, 0, 32'hDE12BEEF);
        for (int i = 0; i < 40 && act1_q.size() < exp1_q.size(); i++) @(posedge clk);
        #1;
        while (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            checks++;
            if (act1_q.size() == 0) begin
                errors++;
                $display("FAIL word_lane: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                a = act1_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL word_lane: err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                             a.err, a.data, a.cyc, e.err, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_extension();
        rsp_t e, a;
        send(0, 0, MEM_B, 0, 32'hB, 32'h0, 1, 0, 32'hFFFFFFDE);
        send(0, 0, MEM_B, 1, 32'hB, 32'h0, 1, 0, 32'h000000DE);
        send(0, 0, MEM_H, 0, 32'h8, 32'h0, 1, 0, 32'hFFFFBEEF);
        send(0, 0, MEM_H, 1, 32'h8, 32'h0, 1, 0, 32'h0000BEEF);
        send(0, 0, MEM_B, 1, 32'h9, 32'h0, 1, 0, 32'h000000BE);
        send(0, 0, MEM_H, 0, 32'hA, 32'h0, 1, 0, 32'hFFFFDE12);
        for (int i = 0; i < 40 && act1_q.size() < exp1_q.size(); i++) @(posedge clk);
        #1;
        while (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            checks++;
            if (act1_q.size() == 0) begin
                errors++;
                $display("FAIL extension: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                a = act1_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL extension: err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                             a.err, a.data, a.cyc, e.err, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_errors();
        rsp_t e, a;
        send(0, 1, MEM_W, 0, 32'h0,    32'h11223344, 1, 0, 32'h0);
        send(0, 1, MEM_W, 0, 32'hFFC,  32'hCAFEF00D, 1, 0, 32'h0);
        send(0, 0, MEM_H, 0, 32'h5,    32'h0,        1, 1, 32'h0);
        send(0, 0, MEM_W, 0, 32'h6,    32'h0,        1, 1, 32'h0);
        send(0, 0, 2'b11, 0, 32'h8,    32'h0,        1, 1, 32'h0);
        send(0, 1, MEM_W, 0, 32'h1002, 32'hAAAAAAAA, 1, 1, 32'h0);
        send(0, 1, MEM_W, 0, 32'h1000, 32'hBBBBBBBB, 1, 1, 32'h0);
        send(0, 1, MEM_H, 0, 32'h9,    32'h7777,     1, 1, 32'h0);
        send(0, 0, MEM_W, 0, 32'h0,    32'h0,        1, 0, 32'h11223344);
        send(0, 0, MEM_W, 0, 32'hFFC,  32'h0,        1, 0, 32'hCAFEF00D);
        send(0, 0, MEM_W, 0, 32'h8,    32'h0,        1, 0, 32'hDE12BEEF);
        for (int i = 0; i < 40 && act1_q.size() < exp1_q.size(); i++) @(posedge clk);
        #1;
        while (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            checks++;
            if (act1_q.size() == 0) begin
                errors++;
                $display("FAIL errors: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                a = act1_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL errors: err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                             a.err, a.data, a.cyc, e.err, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_latency();
        rsp_t e, a;
        logic [31:0] t0;
        send(1, 1, MEM_W, 0, 32'h0, 32'h5, 1, 0, 32'h0);
        checks++;
        if ({ready3, rvalid3} !== 2'b00) begin
            errors++;
            $display("FAIL latency_cycle1: ready=%0b rvalid=%0b, required 0 0", ready3, rvalid3);
        end
        @(posedge clk); #1;
        checks++;
        if ({ready3, rvalid3} !== 2'b00) begin
            errors++;
            $display("FAIL latency_cycle2: ready=%0b rvalid=%0b, required 0 0", ready3, rvalid3);
        end
        @(posedge clk); #1;
        checks++;
        if ({ready3, rvalid3} !== 2'b11) begin
            errors++;
            $display("FAIL latency_cycle3: ready=%0b rvalid=%0b, required 1 1", ready3, rvalid3);
        end
        send(1, 0, MEM_W, 0, 32'h0, 32'h0, 1, 0, 32'h5);
        t0 = last_acc;
        send(1, 1, MEM_W, 0, 32'h0, 32'h7, 1, 0, 32'h0);
        checks++;
        if (last_acc - t0 !== 32'd3) begin
            errors++;
            $display("FAIL latency_throughput: gap=%0d cycles, required 3", last_acc - t0);
        end
        send(1, 0, MEM_W, 0, 32'h0, 32'h0, 1, 0, 32'h7);
        for (int i = 0; i < 40 && act3_q.size() < exp3_q.size(); i++) @(posedge clk);
        #1;
        while (exp3_q.size() != 0) begin
            e = exp3_q.pop_front();
            checks++;
            if (act3_q.size() == 0) begin
                errors++;
                $display("FAIL latency: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                a = act3_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL latency: err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                             a.err, a.data, a.cyc, e.err, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rsp_t e, a;
        send(1, 1, MEM_W, 0, 32'h4, 32'hA5A5A5A5, 1, 0, 32'h0);
        send(1, 0, MEM_H, 0, 32'h5, 32'h0,        1, 1, 32'h0);
        for (int i = 0; i < 40 && act3_q.size() < exp3_q.size(); i++) @(posedge clk);
        #1;
        send(1, 1, MEM_W, 0, 32'h4, 32'h55, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready3, rvalid3, err3, r_data3} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_dut3: ready=%0b rvalid=%0b err=%0b r_data=%h, required 1 0 0 0",
                     ready3, rvalid3, err3, r_data3);
        end
        checks++;
        if ({ready1, rvalid1, err1, r_data1} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_dut1: ready=%0b rvalid=%0b err=%0b r_data=%h, required 1 0 0 0",
                     ready1, rvalid1, err1, r_data1);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(1, 0, MEM_W, 0, 32'h4, 32'h0, 1, 0, 32'hA5A5A5A5);
        for (int i = 0; i < 40 && act3_q.size() < exp3_q.size() + 2; i++) @(posedge clk);
        #1;
        while (exp3_q.size() != 0) begin
            e = exp3_q.pop_front();
            checks++;
            if (act3_q.size() == 0) begin
                errors++;
                $display("FAIL reset_mid: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                a = act3_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL reset_mid: err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                             a.err, a.data, a.cyc, e.err, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (act3_q.size() != 0 || act1_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_spurious: %0d extra responses, required 0",
                     act3_q.size() + act1_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_word_lane();
        test_extension();
        test_errors();
        test_latency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1);
    end

endmodule

// File: doc/data_memory_ext.md
# data_memory_ext

Parametrised, latency-configurable data memory for the multi-cycle and pipelined cores. Little-endian, byte-addressed. Supports byte/half/word loads and stores with sign or zero extension and byte-lane write masking. A request/ready/valid handshake carries one outstanding access at a time. Misaligned, out-of-range and invalid-size accesses are flagged and have no side effects.

## Interface
- `DEPTH`, 1024: number of `DATA_LEN`-bit words; power of two.
- `LATENCY`, 1: cycles from the accept edge to the response cycle; range 1..8.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `req` in 1: access request; sampled only when `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: `MEM_B`=00, `MEM_H`=01, `MEM_W`=10; 11 is invalid.
- `uns` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `addr` in `ADDR_LEN`: byte address.
- `w_data` in `DATA_LEN`: store data, right-justified (byte in [7:0], half in [15:0]).
- `ready` out 1: request can be accepted this cycle.
- `rvalid` out 1: one-cycle response strobe, for both loads and stores.
- `r_data` out `DATA_LEN`: load result, extended; 0 for stores and errors.
- `err` out 1: valid with `rvalid`; flags a misaligned, out-of-range or invalid-size access.

## Operation
- **Accept:** `req && ready` at a rising edge. At that edge `we`, `size`, `uns`, `addr` and `w_data` are latched.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: accept goes to RESP if `LATENCY`==1, otherwise to WAIT with the counter loaded to `LATENCY`-1.
  - WAIT: decrement the counter; go to RESP on the edge where the counter is 1.
  - RESP: accept goes to RESP or WAIT, by the same rule as IDLE; no accept goes to IDLE.
- **Outputs by state:**
  - `ready` = 1 in IDLE and in RESP (back-to-back issue is allowed); 0 in WAIT.
  - `rvalid` = 1 only in RESP.
- **Error conditions:**
  - `size`==11.
  - `size`==H with `addr[0]`=1.
  - `size`==W with `addr[1:0]`≠0.
  - Word index `addr[ADDR_LEN-1:2]` ≥ `DEPTH`.
- **On error:** `err`=1, `r_data`=0, and no array write.
- **Store:**
  - Byte lanes are enabled per `size`/`addr[1:0]`, and `w_data` is shifted into those lanes.
  - Only the enabled lanes of the word are written, on the edge entering RESP.
  - Non-enabled bytes keep their value.
- **Load:**
  - The addressed word is read on the edge entering RESP.
  - The byte or half selected by `addr[1:0]` is extracted and extended per `uns`.
  - The result is registered into `r_data` and held through RESP.
- **Memory array:** not cleared by reset; contents are undefined until written.

## Timing
- Reset (async assert): state IDLE, counter 0, `ready`=1, `rvalid`=0, `r_data`=0, `err`=0.
- Reset deassertion is synchronised externally; the first accept is possible on the first edge after release.
- Accept at edge T. The response is the cycle after edge T+`LATENCY`-1, i.e. `rvalid` is high `LATENCY` cycles after the accept cycle.
- Back-to-back throughput:
  - `LATENCY`==1: one access per cycle.
  - Otherwise: one access every `LATENCY` cycles.
- Store then load to the same address issued back-to-back: the load returns the new data, since the write commits at the edge entering the store's RESP, before the load's read.
- Reset asserted in WAIT: the pending store is dropped with no write, and no response is produced.
- `req` while `ready`=0 is ignored (not queued); the requester holds `req` and the request fields until accepted.

## Structure
- **`defines.v` additions:** `MEM_B`, `MEM_H`, `MEM_W`, and the `MEM_SIZE_LEN`=2 width; reuse `DATA_LEN` and `ADDR_LEN`.
- **Sub-module `dmem_lane_align` (combinational):**
  - Store side: `size` + `addr[1:0]` + `w_data` produce a 4-bit byte enable and the shifted write word.
  - Load side: `size` + `uns` + `addr[1:0]` + read word produce the extended result.
  - Also produces the misalign/invalid-size flag.
- **Top level:** FSM, latency counter, array, request latches, out-of-range compare.

## Test plan
- **Reset values:** `rst_n`=0 mid-sim → `ready`=1, `rvalid`=0, `r_data`=0, `err`=0 immediately, without waiting for a clock edge.
- **Word then byte-lane update** (`LATENCY`=1):
  - SW 0x8 ← 0xDEADBEEF → `rvalid` next cycle, `err`=0.
  - LW 0x8 → 0xDEADBEEF.
  - SB 0xA ← 0x12, then LW 0x8 → 0xDE12BEEF.
- **Extension** (word 0x8 holding 0xDE12BEEF):
  - LB 0xB, `uns`=0 → 0xFFFFFFDE.
  - LBU 0xB → 0x000000DE.
  - LH 0x8 → 0xFFFFBEEF.
  - LHU 0x8 → 0x0000BEEF.
- **Errors:**
  - LH 0x5, LW 0x6, `size`=11 each → `err`=1, `r_data`=0.
  - SW 0x1002 (misaligned) and SW 4·`DEPTH` (out of range) each → `err`=1, array unchanged.
- **Latency** (`LATENCY`=3):
  - Accept at cycle 0 → `rvalid` in cycle 3; `ready`=0 in cycles 1–2.
  - Back-to-back SW 0x0 ← 5 then LW 0x0 → second `rvalid` returns 5.
- **Reset mid-operation:** `LATENCY`=3; SW 0x4 ← 0x55 with `rst_n` pulsed in WAIT → no `rvalid`; a later LW 0x4 returns the prior contents, not 0x55.
